// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding and
// the oversampling ratios the sampler timing is built around.
package uart_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic [CNT_W-1:0] PRESCALE_8  = 6'd8;
  localparam logic [CNT_W-1:0] PRESCALE_16 = 6'd16;
  localparam logic [CNT_W-1:0] PRESCALE_32 = 6'd32;

  // An unsupported ratio would put the vote window outside the bit, so fall back to 16.
  function automatic logic [CNT_W-1:0] sanitize_prescale(input logic [CNT_W-1:0] p);
    case (p)
      PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
      default:                              return PRESCALE_16;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point majority vote around the middle of each bit period: samples at
// edge counts Prescale/2-1, Prescale/2 and Prescale/2+1.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             rx_i,
  input  logic [CNT_W-1:0] edge_cnt_i,
  input  logic [CNT_W-1:0] prescale_i,
  output logic             bit_o
);

  logic [2:0]       smp_q, smp_d;
  logic [CNT_W-1:0] mid;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  always_comb begin
    mid   = prescale_i >> 1;
    smp_d = smp_q;
    if (en_i) begin
      if (edge_cnt_i == mid - CNT_W'(1)) smp_d[0] = rx_i;
      if (edge_cnt_i == mid)             smp_d[1] = rx_i;
      if (edge_cnt_i == mid + CNT_W'(1)) smp_d[2] = rx_i;
    end
  end

  always_ff @(posedge clk_i) begin
    smp_q <= smp_d;
  end

  assign bit_o = majority3(smp_q);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing on an oversampled serial line,
// with one registered outcome pulse (good data, parity error, stop error) per frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e             state_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      prescale_q;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_en_q, par_typ_q;
  logic                  par_fail_q;
  logic                  armed_q;
  logic                  samp_bit;
  logic                  last_edge, last_data, par_bad, stop_bad;

  function automatic logic exp_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return odd ? ~(^d) : ^d;
  endfunction

  uart_rx_sampler u_sampler (
    .clk_i      (CLK),
    .en_i       (state_q != IDLE),
    .rx_i       (RX_IN),
    .edge_cnt_i (cnt_q),
    .prescale_i (prescale_q),
    .bit_o      (samp_bit)
  );

  always_comb begin
    last_edge = (cnt_q == prescale_q - CNT_W'(1));
    cnt_d     = last_edge ? '0 : cnt_q + CNT_W'(1);
    bit_cnt_d = bit_cnt_q + BIT_W'(1);
    last_data = (bit_cnt_q == BIT_W'(DATA_WIDTH - 1));
    shreg_d   = {samp_bit, shreg_q[DATA_WIDTH-1:1]};
    par_bad   = (samp_bit != exp_parity(shreg_q, par_typ_q));
    stop_bad  = ~samp_bit;
  end

  // cnt_q always holds the edge count of the edge being processed, so the
  // cycle-0 edge (count 0) loads 1 for the edge that follows it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      par_fail_q <= 1'b0;
      armed_q    <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (RX_IN) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q    <= START;
            cnt_q      <= CNT_W'(1);
            bit_cnt_q  <= '0;
            par_fail_q <= 1'b0;
            prescale_q <= sanitize_prescale(Prescale);
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
          end
        end
        START: begin
          cnt_q <= cnt_d;
          if (last_edge) state_q <= samp_bit ? IDLE : DATA;
        end
        DATA: begin
          cnt_q <= cnt_d;
          if (last_edge) begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            if (last_data) state_q <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          cnt_q <= cnt_d;
          if (last_edge) begin
            par_fail_q <= par_bad;
            state_q    <= STOP;
          end
        end
        STOP: begin
          cnt_q <= cnt_d;
          if (last_edge) begin
            state_q <= IDLE;
            // A low stop bit may be a break: wait for the line to go high before re-arming.
            armed_q <= ~stop_bad;
            if (!par_fail_q && !stop_bad) begin
              Data_Valid <= 1'b1;
              P_DATA     <= shreg_q;
            end else begin
              par_err <= par_fail_q;
              stp_err <= stop_bad;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus randomized frames with sample
// glitches and mid-frame configuration changes, checked against a frame-level model.
module tb_uart_rx;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX_IN = 1'b1;
  logic [5:0]    Prescale = 6'd8;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid, par_err, stp_err;

  uart_rx #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int            idx;
    logic          dv;
    logic          pe;
    logic          se;
    logic [DW-1:0] pd;
  } ev_t;

  ev_t           ev_q[$];
  int            edge_n = 0;
  int            vectors = 0;
  int            miscompares = 0;
  int            bad_pd = 0;
  logic [DW-1:0] prev_pd = '0;
  logic [DW-1:0] model_pd = '0;

  always @(posedge CLK) edge_n <= edge_n + 1;

  // Record every outcome pulse with the index of the edge that produced it.
  always @(negedge CLK) begin
    if (Data_Valid || par_err || stp_err)
      ev_q.push_back(ev_t'{idx: edge_n - 1, dv: Data_Valid, pe: par_err, se: stp_err, pd: P_DATA});
    if (RST) prev_pd <= P_DATA;
    else begin
      if (P_DATA !== prev_pd && !Data_Valid) bad_pd <= bad_pd + 1;
      prev_pd <= P_DATA;
    end
  end

  // Frame-level reference: a parity bit is correct when the total count of
  // ones (data + parity) is even for even parity, odd for odd parity.
  function automatic void predict(input logic [DW-1:0] d, input bit pen, input bit ptyp,
                                  input bit pbit, input bit sbit,
                                  output bit dv, output bit pe, output bit se);
    int ones;
    ones = $countones(d) + int'(pbit);
    pe = pen && ((ones % 2) != (ptyp ? 1 : 0));
    se = !sbit;
    dv = !pe && !se;
  endfunction

  task automatic take_event(output ev_t e);
    if (ev_q.size() > 0) e = ev_q.pop_front();
    else e = '{idx: -1, dv: 1'b0, pe: 1'b0, se: 1'b0, pd: '0};
  endtask

  // Drives one frame starting at a negedge; the next posedge is cycle 0.
  task automatic send_frame(input int p, input bit pen, input bit ptyp, input logic [DW-1:0] d,
                            input bit pbit, input bit sbit, input bit glitch, input bit scramble,
                            input int abort_bit, output int start);
    logic bits [0:11];
    int   nb;
    int   gpos;
    logic v;
    nb = DW + 2 + int'(pen);
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[i+1] = d[i];
    if (pen) bits[DW+1] = pbit;
    bits[nb-1] = sbit;
    Prescale = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    start    = edge_n;
    for (int b = 0; b < nb; b++) begin
      gpos = (glitch && $urandom_range(0, 1) == 1) ? p / 2 - 1 + int'($urandom_range(0, 2)) : -1;
      for (int c = 0; c < p; c++) begin
        if (b == abort_bit && c == 2) begin
          RST = 1'b1;
          repeat (2) @(negedge CLK);
          RST   = 1'b0;
          RX_IN = 1'b1;
          return;
        end
        v = bits[b];
        if (c == gpos) v = ~v;
        RX_IN = v;
        if (scramble && b == 2 && c == 0) begin
          Prescale = (p == 8) ? 6'd32 : 6'd8;
          PAR_EN   = ~pen;
          PAR_TYP  = ~ptyp;
        end
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    vectors++; if (P_DATA !== '0) begin miscompares++; $display("FAIL reset_pdata got=%0h exp=0", P_DATA); end
    vectors++; if ({Data_Valid, par_err, stp_err} !== 3'b000) begin
      miscompares++; $display("FAIL reset_pulses got=%b exp=000", {Data_Valid, par_err, stp_err}); end
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    vectors++; if (ev_q.size() !== 0) begin miscompares++; $display("FAIL reset_idle_events got=%0d exp=0", ev_q.size()); end
  endtask

  task automatic test_good_parity();
    int s; int n; ev_t e;
    ev_q.delete();
    send_frame(8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, -1, s);
    RX_IN = 1'b1; @(negedge CLK);
    n = ev_q.size(); take_event(e);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL a5_count got=%0d exp=1", n); end
    vectors++; if (e.idx - s !== 87) begin miscompares++; $display("FAIL a5_latency got=%0d exp=87", e.idx - s); end
    vectors++; if ({e.dv, e.pe, e.se} !== 3'b100) begin miscompares++; $display("FAIL a5_flags got=%b exp=100", {e.dv, e.pe, e.se}); end
    vectors++; if (P_DATA !== 8'hA5) begin miscompares++; $display("FAIL a5_pdata got=%0h exp=a5", P_DATA); end
    model_pd = 8'hA5;
  endtask

  task automatic test_parity_error();
    int s; int n; ev_t e;
    ev_q.delete();
    send_frame(8, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, -1, s);
    RX_IN = 1'b1; @(negedge CLK);
    n = ev_q.size(); take_event(e);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL par_count got=%0d exp=1", n); end
    vectors++; if (e.idx - s !== 87) begin miscompares++; $display("FAIL par_latency got=%0d exp=87", e.idx - s); end
    vectors++; if ({e.dv, e.pe, e.se} !== 3'b010) begin miscompares++; $display("FAIL par_flags got=%b exp=010", {e.dv, e.pe, e.se}); end
    vectors++; if (P_DATA !== model_pd) begin miscompares++; $display("FAIL par_pdata_held got=%0h exp=%0h", P_DATA, model_pd); end
    vectors++; if (bad_pd !== 0) begin miscompares++; $display("FAIL par_pdata_changes got=%0d exp=0", bad_pd); end
  endtask

  task automatic test_stop_error();
    int s; int n; ev_t e;
    ev_q.delete();
    send_frame(16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1, s);
    RX_IN = 1'b1; @(negedge CLK);
    n = ev_q.size(); take_event(e);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL stp_count got=%0d exp=1", n); end
    vectors++; if (e.idx - s !== 159) begin miscompares++; $display("FAIL stp_latency got=%0d exp=159", e.idx - s); end
    vectors++; if ({e.dv, e.pe, e.se} !== 3'b001) begin miscompares++; $display("FAIL stp_flags got=%b exp=001", {e.dv, e.pe, e.se}); end
    vectors++; if (P_DATA !== model_pd) begin miscompares++; $display("FAIL stp_pdata_held got=%0h exp=%0h", P_DATA, model_pd); end
    repeat (4) @(negedge CLK);
    send_frame(16, 1'b0, 1'b0, 8'h3E, 1'b0, 1'b1, 1'b0, 1'b0, -1, s);
    RX_IN = 1'b1; @(negedge CLK);
    take_event(e);
    vectors++; if (e.idx - s !== 159 || e.dv !== 1'b1) begin
      miscompares++; $display("FAIL stp_recover got=%0d/%b exp=159/1", e.idx - s, e.dv); end
    vectors++; if (P_DATA !== 8'h3E) begin miscompares++; $display("FAIL stp_recover_pdata got=%0h exp=3e", P_DATA); end
    model_pd = 8'h3E;
  endtask

  task automatic test_glitch();
    int s; ev_t e;
    ev_q.delete();
    Prescale = 6'd8; PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (20) @(negedge CLK);
    vectors++; if (ev_q.size() !== 0) begin miscompares++; $display("FAIL glitch_events got=%0d exp=0", ev_q.size()); end
    send_frame(8, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0, 1'b0, -1, s);
    RX_IN = 1'b1; @(negedge CLK);
    take_event(e);
    vectors++; if (e.idx - s !== 79 || e.dv !== 1'b1) begin
      miscompares++; $display("FAIL glitch_recover got=%0d/%b exp=79/1", e.idx - s, e.dv); end
    vectors++; if (P_DATA !== 8'h96) begin miscompares++; $display("FAIL glitch_pdata got=%0h exp=96", P_DATA); end
    model_pd = 8'h96;
  endtask

  task automatic test_back_to_back();
    int s1; int s2; int n; ev_t e1; ev_t e2;
    ev_q.delete();
    send_frame(32, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, -1, s1);
    send_frame(32, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, -1, s2);
    RX_IN = 1'b1; @(negedge CLK);
    n = ev_q.size(); take_event(e1); take_event(e2);
    vectors++; if (n !== 2) begin miscompares++; $display("FAIL b2b_count got=%0d exp=2", n); end
    vectors++; if (e1.idx - s1 !== 319 || e1.dv !== 1'b1 || e1.pd !== 8'h55) begin
      miscompares++; $display("FAIL b2b_first got=%0d/%b/%0h exp=319/1/55", e1.idx - s1, e1.dv, e1.pd); end
    vectors++; if (e2.idx - s2 !== 319 || e2.dv !== 1'b1 || e2.pd !== 8'hAA) begin
      miscompares++; $display("FAIL b2b_second got=%0d/%b/%0h exp=319/1/aa", e2.idx - s2, e2.dv, e2.pd); end
    model_pd = 8'hAA;
  endtask

  task automatic test_reset_midframe();
    int s; ev_t e;
    ev_q.delete();
    send_frame(8, 1'b0, 1'b0, 8'h3F, 1'b0, 1'b1, 1'b0, 1'b0, 4, s);
    vectors++; if (P_DATA !== '0) begin miscompares++; $display("FAIL rstmid_pdata got=%0h exp=0", P_DATA); end
    vectors++; if ({Data_Valid, par_err, stp_err} !== 3'b000) begin
      miscompares++; $display("FAIL rstmid_pulses got=%b exp=000", {Data_Valid, par_err, stp_err}); end
    model_pd = '0;
    repeat (100) @(negedge CLK);
    vectors++; if (ev_q.size() !== 0) begin miscompares++; $display("FAIL rstmid_events got=%0d exp=0", ev_q.size()); end
    send_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, -1, s);
    RX_IN = 1'b1; @(negedge CLK);
    take_event(e);
    vectors++; if (e.idx - s !== 79 || e.dv !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_next got=%0d/%b exp=79/1", e.idx - s, e.dv); end
    vectors++; if (P_DATA !== 8'h81) begin miscompares++; $display("FAIL rstmid_next_pdata got=%0h exp=81", P_DATA); end
    model_pd = 8'h81;
  endtask

  task automatic test_break();
    int s; int n; ev_t e;
    ev_q.delete();
    send_frame(8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, -1, s);
    RX_IN = 1'b0;
    repeat (40) @(negedge CLK);
    n = ev_q.size(); take_event(e);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL break_count got=%0d exp=1", n); end
    vectors++; if (e.idx - s !== 79 || {e.dv, e.pe, e.se} !== 3'b001) begin
      miscompares++; $display("FAIL break_event got=%0d/%b exp=79/001", e.idx - s, {e.dv, e.pe, e.se}); end
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    send_frame(8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, -1, s);
    RX_IN = 1'b1; @(negedge CLK);
    take_event(e);
    vectors++; if (e.idx - s !== 79 || e.dv !== 1'b1 || P_DATA !== 8'hC3) begin
      miscompares++; $display("FAIL break_recover got=%0d/%b/%0h exp=79/1/c3", e.idx - s, e.dv, P_DATA); end
    model_pd = 8'hC3;
  endtask

  task automatic test_random();
    int s; int n; int p; int nbits; ev_t e;
    bit pen, ptyp, pbit, sbit, dv, pe, se;
    logic [DW-1:0] d;
    ev_q.delete();
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      pbit = 1'($urandom_range(0, 1));
      sbit = ($urandom_range(0, 4) != 0);
      d    = DW'($urandom);
      send_frame(p, pen, ptyp, d, pbit, sbit, 1'b1, 1'($urandom_range(0, 1)), -1, s);
      RX_IN = 1'b1; @(negedge CLK);
      predict(d, pen, ptyp, pbit, sbit, dv, pe, se);
      if (dv) model_pd = d;
      nbits = DW + 2 + int'(pen);
      n = ev_q.size(); take_event(e);
      vectors++; if (n !== 1) begin miscompares++; $display("FAIL rnd%0d_count got=%0d exp=1", k, n); end
      vectors++; if (e.idx - s !== nbits * p - 1) begin
        miscompares++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", k, e.idx - s, nbits * p - 1); end
      vectors++; if ({e.dv, e.pe, e.se} !== {dv, pe, se}) begin
        miscompares++; $display("FAIL rnd%0d_flags got=%b exp=%b", k, {e.dv, e.pe, e.se}, {dv, pe, se}); end
      vectors++; if (P_DATA !== model_pd) begin
        miscompares++; $display("FAIL rnd%0d_pdata got=%0h exp=%0h", k, P_DATA, model_pd); end
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    vectors++; if (bad_pd !== 0) begin miscompares++; $display("FAIL rnd_pdata_changes got=%0d exp=0", bad_pd); end
  endtask

  initial begin
    test_reset();
    test_good_parity();
    test_parity_error();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_break();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DATA_WIDTH, 8, number of data bits per frame (LSB first).
REQ-002 CLK  input  1  system clock; oversampling clock, Prescale cycles per bit.
REQ-003 RST  input  1  synchronous reset, active-high.
REQ-004 RX_IN  input  1  serial line, idle high; already synchronised to CLK.
REQ-005 Prescale  input  6  oversampling ratio; supported values 8, 16, 32.
REQ-006 PAR_EN  input  1  1 = frame carries a parity bit after the data bits.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 P_DATA  output  DATA_WIDTH  last correctly received data word.
REQ-009 Data_Valid  output  1  one-cycle pulse: P_DATA updated with a good frame.
REQ-010 par_err  output  1  one-cycle pulse: parity mismatch in the frame just ended.
REQ-011 stp_err  output  1  one-cycle pulse: stop bit sampled as 0.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-013 Cycle 0 of a frame SHALL be the first CLK edge in IDLE at which RX_IN is 0; it sets edge count 0 and moves to START.
REQ-014 Edge counter SHALL count 0..Prescale-1 per bit, then wrap to 0 and advance the bit counter.
REQ-015 Each bit value SHALL be the majority of three RX_IN samples at edge counts Prescale/2-1, Prescale/2, and Prescale/2+1.
REQ-016 START: at edge Prescale-1, a sampled value of 1 SHALL return the FSM to IDLE with no output pulse (glitch); a 0 SHALL move it to DATA.
REQ-017 DATA: DATA_WIDTH bits, LSB first, shifted into an internal register; after the last bit go to PARITY if PAR_EN=1, else to STOP.
REQ-018 PARITY: expected bit SHALL be XOR of the data bits for even and XNOR for odd; a mismatch SHALL set an internal parity-fail flag.
REQ-019 STOP: a sampled 0 SHALL set an internal stop-fail flag.
REQ-020 At edge Prescale-1 of the stop bit, the FSM SHALL return to IDLE, and on that edge SHALL register exactly one outcome: Data_Valid=1 with P_DATA loaded if both flags are clear, otherwise par_err and/or stp_err =1.
REQ-021 Latency: the outcome pulses SHALL be visible after edge N*Prescale-1 relative to cycle 0, with N = DATA_WIDTH+2 (+1 if PAR_EN).
REQ-022 Prescale, PAR_EN and PAR_TYP SHALL be captured at cycle 0 and held for the frame; mid-frame changes SHALL have no effect.
REQ-023 P_DATA SHALL change only on Data_Valid; errored frames SHALL leave it unchanged.
REQ-024 Back-to-back frames: a start bit whose first low sample arrives on the cycle after the IDLE return SHALL be received correctly.
REQ-025 A line held low (break) SHALL produce stp_err once and then re-enter START only after RX_IN has been seen high in IDLE.

Reset
REQ-026 RST=1 SHALL force IDLE, clear counters and flags, and set P_DATA=0, Data_Valid=0, par_err=0, stp_err=0 on the next CLK edge.
REQ-027 RST asserted mid-frame SHALL abandon the frame with no output pulse.

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state enum and the supported Prescale constants (8, 16, 32).
REQ-029 Majority-vote sampling SHALL live in one sub-module, uart_rx_sampler; the FSM, counters and checks stay in uart_rx.

Verification
REQ-030 Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 and stop 1 -> single Data_Valid, P_DATA=0xA5, no errors, pulse after edge 87.
REQ-031 Prescale=8, PAR_EN=1, PAR_TYP=1, frame 0x3C sent with parity 0 -> par_err=1 for one cycle, Data_Valid=0, P_DATA unchanged.
REQ-032 Prescale=16, PAR_EN=0, frame 0x55 with stop bit 0 -> stp_err one cycle, Data_Valid=0; then RX_IN high -> FSM in IDLE.
REQ-033 Prescale=8, RX_IN low for 3 cycles then high -> FSM returns to IDLE, no output pulses.
REQ-034 Prescale=32, PAR_EN=0, frames 0x55 then 0xAA with zero idle between them -> two Data_Valid pulses, P_DATA 0x55 then 0xAA.
REQ-035 RST=1 at DATA bit 3 of a frame, then released -> all outputs 0, no pulse for that frame, next frame 0x81 received correctly.
